gate_seq_ctrl: RTL

Self-checking sequencer for a 2-input combinational gate under test (e.g. prim_or). On a start request it walks all four input combinations and drives them onto the gate. It waits a programmable settle time, samples the gate output and compares it against a parameterised truth table. It then reports per-vector mismatches and an overall pass flag, replacing hand-written delay-based stimulus in gate benches and in on-chip self-test wrappers.

---
 rtl/gate_seq_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gate_seq_ctrl.sv
// Walks all four input vectors of a 2-input gate, waits SETTLE cycles per vector,
// and checks the gate output against the EXPECT truth table. All outputs are registered.
module gate_seq_ctrl #(
    parameter int         SETTLE = 2,
    parameter int         CNT_W  = 4,
    parameter logic [3:0] EXPECT = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       z_in,
    output logic       a_out,
    output logic       b_out,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         fail_mask_q, fail_mask_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               a_q, a_d;
    logic               b_q, b_d;

    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        cnt_d       = cnt_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_DRIVE;
                    fail_mask_d = 4'b0000;
                    pass_d      = 1'b0;
                    vec_idx_d   = 2'd0;
                end
            end
            S_DRIVE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Case inequality so an X/Z from the gate is flagged in simulation.
                if (z_in !== EXPECT[vec_idx_q]) begin
                    fail_mask_d[vec_idx_q] = 1'b1;
                end
                if (vec_idx_q == 2'd3) begin
                    state_d = S_DONE;
                    pass_d  = (fail_mask_d == 4'b0000);
                end else begin
                    vec_idx_d = vec_idx_q + 2'd1;
                    state_d   = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are valid in the state's own cycle.
        busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        a_d    = busy_d & vec_idx_d[1];
        b_d    = busy_d & vec_idx_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vec_idx_q   <= 2'd0;
            cnt_q       <= '0;
            fail_mask_q <= 4'b0000;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            cnt_q       <= cnt_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign vec_idx   = vec_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;

endmodule
